// File: rtl/bus.sv
// Single-master system bus: one master, two memory-mapped slaves.
// The master is granted the bus one cycle after it requests it.
// Address, write strobe and write data are forwarded to the slaves while the
// master holds the grant. The address is decoded into per-slave selects, and
// read data is returned from the slave that was selected in the previous cycle.
//
// Address map (fixed):
//   0x00-0x1F  slave 0
//   0x20-0x3F  slave 1
//   0x40-0xFF  unmapped (no select, read data returns 0)

package bus_pkg;

    // Arbiter state. The encoding matches the grant level: GRANT is 1.
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_e;

endpackage


// ---------------------------------------------------------------------------
// Arbiter: a two-state grant FSM.
// state_o is the registered state. M_grant is taken directly from this flop,
// so it is also the debug view of the FSM.
// ---------------------------------------------------------------------------
module bus_arbiter (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                req_i,
    output bus_pkg::arb_state_e state_o
);
    import bus_pkg::*;

    arb_state_e state_q;

    // Grant FSM: a request grants the bus, and a dropped request releases it.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_i) begin
                        state_q <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    if (!req_i) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign state_o = state_q;

endmodule


// ---------------------------------------------------------------------------
// Decoder: gates forwarding and selects with the grant.
// Without the grant, every slave-facing signal is held at zero, so the slaves
// see an idle bus.
// ---------------------------------------------------------------------------
module bus_decoder (
    input  logic        grant_i,
    input  logic        wr_i,
    input  logic [7:0]  addr_i,
    input  logic [31:0] wdata_i,
    output logic        s0_sel_o,
    output logic        s1_sel_o,
    output logic [7:0]  s_addr_o,
    output logic        s_wr_o,
    output logic [31:0] s_din_o
);
    // Region index: addr[7:5] selects a 32-byte window.
    logic [2:0] region;

    assign region = addr_i[7:5];

    // Forward master signals to the slaves only while the master is granted.
    always_comb begin
        s_addr_o = 8'h00;
        s_wr_o   = 1'b0;
        s_din_o  = 32'h0;
        if (grant_i) begin
            s_addr_o = addr_i;
            s_wr_o   = wr_i;
            s_din_o  = wdata_i;
        end
    end

    // One-hot slave select. Both selects are zero for unmapped regions.
    always_comb begin
        s0_sel_o = 1'b0;
        s1_sel_o = 1'b0;
        if (grant_i) begin
            case (region)
                3'b000:  s0_sel_o = 1'b1;
                3'b001:  s1_sel_o = 1'b1;
                default: begin
                    s0_sel_o = 1'b0;
                    s1_sel_o = 1'b0;
                end
            endcase
        end
    end

endmodule


// ---------------------------------------------------------------------------
// Read mux: registers the selects and steers the read data.
// The slaves are synchronous and present read data one cycle after they are
// selected. This block therefore remembers the selects from the previous
// cycle and uses them to choose the return data.
// Write cycles also update the registered select. The master ignores the
// return data during writes.
// ---------------------------------------------------------------------------
module bus_rdmux (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        s0_sel_i,
    input  logic        s1_sel_i,
    input  logic [31:0] s0_rdata_i,
    input  logic [31:0] s1_rdata_i,
    output logic [31:0] rdata_o
);
    // Bit 1 is the slave 1 select and bit 0 is the slave 0 select.
    logic [1:0] sel_d;
    logic [1:0] sel_q;

    assign sel_d = {s1_sel_i, s0_sel_i};

    // Capture the selects on every edge. They are already gated by the grant.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sel_q <= 2'b00;
        end else begin
            sel_q <= sel_d;
        end
    end

    // Return data from the slave captured last cycle, or zero if none.
    always_comb begin
        rdata_o = 32'h0;
        case (sel_q)
            2'b01:   rdata_o = s0_rdata_i;
            2'b10:   rdata_o = s1_rdata_i;
            default: rdata_o = 32'h0;
        endcase
    end

endmodule


// ---------------------------------------------------------------------------
// Top level.
//
// Handshake: M_req is the master's request level, and M_grant is the bus's
// registered answer. A transfer happens on every cycle in which M_grant is 1.
// Address, write strobe and data are presented in that cycle, and read data
// returns on M_din in the following cycle. The master holds M_req high for
// as long as it wants the bus. Dropping M_req releases the grant at the next
// edge.
//
// reset_n is active-high despite its name. The port keeps its legacy name.
// ---------------------------------------------------------------------------
module bus (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        M_req,
    input  logic        M_wr,
    input  logic [7:0]  M_addr,
    input  logic [31:0] M_dout,
    input  logic [31:0] S0_dout,
    input  logic [31:0] S1_dout,
    output logic        M_grant,
    output logic [31:0] M_din,
    output logic        S0_sel,
    output logic        S1_sel,
    output logic [7:0]  S_addr,
    output logic        S_wr,
    output logic [31:0] S_din
);
    import bus_pkg::*;

    arb_state_e arb_state;

    bus_arbiter u_arbiter (
        .clk_i   (clk),
        .rst_i   (reset_n),
        .req_i   (M_req),
        .state_o (arb_state)
    );

    // The grant is the arbiter's state flop itself.
    assign M_grant = (arb_state == ST_GRANT);

    bus_decoder u_decoder (
        .grant_i  (M_grant),
        .wr_i     (M_wr),
        .addr_i   (M_addr),
        .wdata_i  (M_dout),
        .s0_sel_o (S0_sel),
        .s1_sel_o (S1_sel),
        .s_addr_o (S_addr),
        .s_wr_o   (S_wr),
        .s_din_o  (S_din)
    );

    bus_rdmux u_rdmux (
        .clk_i      (clk),
        .rst_i      (reset_n),
        .s0_sel_i   (S0_sel),
        .s1_sel_i   (S1_sel),
        .s0_rdata_i (S0_dout),
        .s1_rdata_i (S1_dout),
        .rdata_o    (M_din)
    );

endmodule

// File: tb/tb_bus.sv
// Bench for the single-master bus.
// It runs directed steps from the test plan, then a randomized run.
// All outputs are checked once per cycle against a behavioural model.
// The model reasons about "which slave does this address belong to" and
// "which slave was used last cycle".
module tb_bus;

  // ---------------- clock / reset ----------------
  logic        clk;
  logic        reset_n;
  logic        M_req;
  logic        M_wr;
  logic [7:0]  M_addr;
  logic [31:0] M_dout;
  logic [31:0] S0_dout;
  logic [31:0] S1_dout;
  logic        M_grant;
  logic [31:0] M_din;
  logic        S0_sel;
  logic        S1_sel;
  logic [7:0]  S_addr;
  logic        S_wr;
  logic [31:0] S_din;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  bus dut (
    .clk     (clk),
    .reset_n (reset_n),
    .M_req   (M_req),
    .M_wr    (M_wr),
    .M_addr  (M_addr),
    .M_dout  (M_dout),
    .S0_dout (S0_dout),
    .S1_dout (S1_dout),
    .M_grant (M_grant),
    .M_din   (M_din),
    .S0_sel  (S0_sel),
    .S1_sel  (S1_sel),
    .S_addr  (S_addr),
    .S_wr    (S_wr),
    .S_din   (S_din)
  );

  // ---------------- reference model ----------------
  int n_checks = 0;
  int n_fail   = 0;
  bit m_granted = 1'b0;  // master currently owns the bus
  int m_last    = -1;    // slave used in the previous cycle (-1 = none)

  // Slave owning an address: 32-byte windows, only the first two are mapped.
  function automatic int slave_of(input logic [7:0] a);
    int idx;
    idx = int'(a) / 32;
    if (idx < 2) return idx;
    return -1;
  endfunction

  // ---------------- scoreboard ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    int cur;
    logic [31:0] exp_din;
    cur = m_granted ? slave_of(M_addr) : -1;
    if (m_last == 0)      exp_din = S0_dout;
    else if (m_last == 1) exp_din = S1_dout;
    else                  exp_din = 32'h0;
    chk("M_grant", {31'h0, M_grant}, {31'h0, m_granted});
    chk("S0_sel",  {31'h0, S0_sel},  {31'h0, (cur == 0)});
    chk("S1_sel",  {31'h0, S1_sel},  {31'h0, (cur == 1)});
    chk("S_addr",  {24'h0, S_addr},  m_granted ? {24'h0, M_addr} : 32'h0);
    chk("S_wr",    {31'h0, S_wr},    {31'h0, (m_granted & M_wr)});
    chk("S_din",   S_din,            m_granted ? M_dout : 32'h0);
    chk("M_din",   M_din,            exp_din);
  endtask

  // ---------------- driver ----------------
  // Drives one cycle: inputs change at the falling edge and are checked 1
  // time unit later. The model then advances at the rising edge.
  task automatic cycle(input bit rst, input bit req, input bit wr,
                       input logic [7:0] addr, input logic [31:0] wdata,
                       input logic [31:0] s0d, input logic [31:0] s1d);
    @(negedge clk);
    reset_n = rst;
    M_req   = req;
    M_wr    = wr;
    M_addr  = addr;
    M_dout  = wdata;
    S0_dout = s0d;
    S1_dout = s1d;
    if (rst) begin
      m_granted = 1'b0;
      m_last    = -1;
    end
    #1;
    check_all();
    @(posedge clk);
    if (!rst) begin
      m_last    = m_granted ? slave_of(addr) : -1;
      m_granted = req;
    end
  endtask

  // ---------------- stimulus ----------------
  logic [7:0]  s1_addrs[5];
  logic [31:0] s1_data[5];
  logic [7:0]  r_addr;

  initial begin
    reset_n = 1'b1;
    M_req   = 1'b0;
    M_wr    = 1'b0;
    M_addr  = 8'h00;
    M_dout  = 32'h0;
    S0_dout = 32'h0;
    S1_dout = 32'h0;

    s1_addrs = '{8'h21, 8'h2F, 8'h30, 8'h3A, 8'h3F};
    s1_data  = '{32'h3, 32'h4, 32'hD, 32'hE, 32'hF};

    // Reset held with a pending request: everything stays zero.
    cycle(1, 1, 0, 8'h30, 32'h55, 32'hAAAA, 32'hBBBB);
    cycle(1, 1, 0, 8'h30, 32'h55, 32'hAAAA, 32'hBBBB);
    // Release: grant appears one edge later.
    cycle(0, 1, 0, 8'h30, 32'h55, 32'hAAAA, 32'hBBBB);

    // Writes to slave 0.
    cycle(0, 1, 1, 8'h0A, 32'h0B, 32'h0, 32'h0);
    cycle(0, 1, 1, 8'h00, 32'h0B, 32'h0, 32'h0);
    cycle(0, 1, 1, 8'h0F, 32'h0B, 32'h0, 32'h0);

    // Writes to slave 1 across its window.
    for (int i = 0; i < 5; i++)
      cycle(0, 1, 1, s1_addrs[i], s1_data[i], 32'h0, 32'h0);

    // Read return, alternating between the two slaves.
    cycle(0, 1, 0, 8'h0F, 32'h0, 32'h1, 32'h2);
    cycle(0, 1, 0, 8'h30, 32'h0, 32'h1, 32'h2);
    cycle(0, 1, 0, 8'h0F, 32'h0, 32'h1, 32'h2);
    cycle(0, 1, 0, 8'h30, 32'h0, 32'h1, 32'h2);

    // Unmapped addresses.
    cycle(0, 1, 0, 8'h40, 32'h0, 32'h1, 32'h2);
    cycle(0, 1, 0, 8'hFF, 32'h0, 32'h1, 32'h2);
    cycle(0, 1, 0, 8'h30, 32'h0, 32'h1, 32'h2);

    // Grant withdrawal while addressing slave 1.
    cycle(0, 0, 0, 8'h30, 32'h7, 32'h1, 32'h2);
    cycle(0, 0, 0, 8'h30, 32'h7, 32'h1, 32'h2);
    cycle(0, 0, 0, 8'h30, 32'h7, 32'h1, 32'h2);

    // Reset in the middle of a granted transfer.
    cycle(0, 1, 0, 8'h05, 32'h0, 32'h11, 32'h22);
    cycle(0, 1, 0, 8'h05, 32'h0, 32'h11, 32'h22);
    cycle(1, 1, 0, 8'h05, 32'h0, 32'h11, 32'h22);
    cycle(0, 1, 0, 8'h05, 32'h0, 32'h11, 32'h22);
    cycle(0, 1, 0, 8'h05, 32'h0, 32'h11, 32'h22);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(1, 0) == 1) r_addr = 8'($urandom_range(63, 0));
      else                           r_addr = 8'($urandom_range(255, 0));
      cycle(($urandom_range(39, 0) == 0),
            ($urandom_range(4, 0) != 0),
            1'($urandom_range(1, 0)),
            r_addr, $urandom, $urandom, $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
